reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 2..255: WAIT cycles without registerAck before the arbiter aborts the transaction.
REQ-002 clockCore  in  1  single clock; all logic on its rising edge.
REQ-003 resetCore  in  1  reset, synchronous and active-low.
REQ-004 masterSelect0..3  in  1 each  level request; held high until the matching masterAck pulse.
REQ-005 masterRead0..3  in  1 each  1=read, 0=write; valid while masterSelect is high.
REQ-006 masterAddress0..3, masterWriteData0..3  in  32 each  request address and write data; stable while masterSelect is high.
REQ-007 masterAck0..3  out  1 each  one-cycle completion pulse to the granted master.
REQ-008 masterError  out  1  error status; valid only with a masterAck pulse.
REQ-009 masterReadData  out  32  read data; valid only with a masterAck pulse.
REQ-010 registerSelect  out  1  one-cycle strobe to the downstream register decode bus.
REQ-011 registerRead, registerAddress, registerWriteData  out  1/32/32  downstream command fields.
REQ-012 registerAck, registerError, registerReadData  in  1/1/32  downstream completion.
REQ-013 grantId  out  2  index of the current or last granted master.
REQ-014 busy  out  1  high in ISSUE, WAIT and DONE.
REQ-015 busTimeout  out  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one outstanding downstream transaction at any time.
REQ-017 IDLE: if any masterSelect is high at an edge, latch the winner's index, read flag, address and write data, then go to ISSUE.
REQ-018 Arbitration: round-robin; search starts at lastGrant+1 mod 4; lastGrant updates on each grant; reset lastGrant=3, so master0 wins first.
REQ-019 ISSUE lasts one cycle: registerSelect=1 with the latched fields; next state WAIT.
REQ-020 registerAddress, registerWriteData and registerRead hold latched values from ISSUE until the next grant; registerRead is low whenever registerSelect is low.
REQ-021 WAIT: registerAck sampled only here; the 8-bit wait counter clears on entry and increments per WAIT cycle.
REQ-022 Ack in WAIT: latch registerError and registerReadData, go to DONE.
REQ-023 No ack when counter==TIMEOUT_CYCLES-1: go to DONE with error=1, readData=32'hDEAD_BEEF, busTimeout pulsed for one cycle on entry to DONE.
REQ-024 Ack and timeout in the same cycle: ack wins; no busTimeout pulse.
REQ-025 DONE lasts one cycle: masterAck[grantId]=1 with masterError/masterReadData; other masterAcks 0; next state IDLE with no arbitration in DONE.
REQ-026 Latency: request seen at cycle N -> registerSelect at N+1; registerAck at cycle M -> masterAck at M+1; IDLE at M+2.
REQ-027 registerAck outside WAIT (stray or late after a timeout) is ignored: no state, data or output change.
REQ-028 Requests are sampled only at grant; a master dropping masterSelect mid-transaction does not cancel it, and its masterAck still pulses.
REQ-029 masterError and masterReadData hold their last value outside DONE.

Reset
REQ-030 resetCore low at an edge forces: IDLE, lastGrant=3, counter=0, grantId=0; all strobes and pulses 0; registerAddress, registerWriteData, masterReadData=0; masterError=0.
REQ-031 Reset mid-transaction abandons it with no masterAck; a later registerAck is ignored per REQ-027.

Verification
REQ-032 Single read: master2 reads 0x0000_0104, downstream acks 3 cycles after select with data 0x1234_5678 -> registerSelect at N+1, masterAck2 and data 0x1234_5678 exactly 4 cycles later, error=0.
REQ-033 Fairness: all four masters hold requests for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each with one registerSelect.
REQ-034 Timeout: TIMEOUT_CYCLES=4, no ack -> masterAck with error=1, data 0xDEAD_BEEF, busTimeout pulse; ack one cycle later ignored.
REQ-035 Ack on the final timeout cycle -> normal completion with downstream data, no busTimeout.
REQ-036 Write by master1 with downstream registerError=1 -> masterAck1 with masterError=1; registerRead=0 throughout.
REQ-037 Reset asserted in WAIT -> outputs at reset values next cycle; master0 wins first afterwards.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//
// Arbitrates four register-bus masters onto a single downstream register
// decode bus. Masters are served round-robin, one outstanding downstream
// transaction at a time. A transaction that sees no downstream ack within
// TIMEOUT_CYCLES wait cycles is aborted and reported to its master as an
// error carrying the 0xDEAD_BEEF poison pattern.
//
// Parameters
//   TIMEOUT_CYCLES     wait cycles without registerAck before abort (2..255)
//
// Ports
//   clockCore          single clock, rising edge
//   resetCore          synchronous, active-low reset
//   masterSelect0..3   level request, held until the matching masterAck
//   masterRead0..3     1 = read, 0 = write
//   masterAddress0..3  request address
//   masterWriteData0..3 request write data
//   masterAck0..3      one-cycle completion pulse to the granted master
//   masterError        completion status, valid with masterAck
//   masterReadData     completion read data, valid with masterAck
//   registerSelect     one-cycle command strobe to the downstream bus
//   registerRead       read flag, only high together with registerSelect
//   registerAddress    latched command address
//   registerWriteData  latched command write data
//   registerAck        downstream completion, sampled only while waiting
//   registerError      downstream error status
//   registerReadData   downstream read data
//   grantId            index of the current or most recent grant
//   busy               transaction in flight (ISSUE, WAIT or DONE)
//   busTimeout         one-cycle pulse when a transaction is aborted
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clockCore,
   input  logic        resetCore,

   input  logic        masterSelect0,
   input  logic        masterSelect1,
   input  logic        masterSelect2,
   input  logic        masterSelect3,
   input  logic        masterRead0,
   input  logic        masterRead1,
   input  logic        masterRead2,
   input  logic        masterRead3,
   input  logic [31:0] masterAddress0,
   input  logic [31:0] masterAddress1,
   input  logic [31:0] masterAddress2,
   input  logic [31:0] masterAddress3,
   input  logic [31:0] masterWriteData0,
   input  logic [31:0] masterWriteData1,
   input  logic [31:0] masterWriteData2,
   input  logic [31:0] masterWriteData3,

   output logic        masterAck0,
   output logic        masterAck1,
   output logic        masterAck2,
   output logic        masterAck3,
   output logic        masterError,
   output logic [31:0] masterReadData,

   output logic        registerSelect,
   output logic        registerRead,
   output logic [31:0] registerAddress,
   output logic [31:0] registerWriteData,
   input  logic        registerAck,
   input  logic        registerError,
   input  logic [31:0] registerReadData,

   output logic [1:0]  grantId,
   output logic        busy,
   output logic        busTimeout
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] POISON_DATA  = 32'hDEAD_BEEF;

   // Gather the per-master scalar ports into indexable form.
   logic [3:0]  req;
   logic [3:0]  req_read;
   logic [31:0] req_addr  [4];
   logic [31:0] req_wdata [4];

   assign req      = {masterSelect3, masterSelect2, masterSelect1, masterSelect0};
   assign req_read = {masterRead3, masterRead2, masterRead1, masterRead0};

   assign req_addr[0]  = masterAddress0;
   assign req_addr[1]  = masterAddress1;
   assign req_addr[2]  = masterAddress2;
   assign req_addr[3]  = masterAddress3;
   assign req_wdata[0] = masterWriteData0;
   assign req_wdata[1] = masterWriteData1;
   assign req_wdata[2] = masterWriteData2;
   assign req_wdata[3] = masterWriteData3;

   // State
   logic [1:0]  state;
   logic [1:0]  last_grant;
   logic [1:0]  grant_id;
   logic [7:0]  wait_count;
   logic        cmd_select;
   logic        cmd_read;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  ack_vec;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic        timeout_pulse;

   // Round-robin pick: scan offsets 1..4 from the last grant. Offset 4 wraps
   // to the last grant itself, so a lone repeat requester still wins.
   logic       win_valid;
   logic [1:0] win_id;
   logic [1:0] cand;

   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = last_grant + 2'(i);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_ff @(posedge clockCore) begin
      if (!resetCore) begin
         state         <= ST_IDLE;
         last_grant    <= 2'd3;
         grant_id      <= '0;
         wait_count    <= '0;
         cmd_select    <= 1'b0;
         cmd_read      <= 1'b0;
         cmd_addr      <= '0;
         cmd_wdata     <= '0;
         ack_vec       <= '0;
         rsp_error     <= 1'b0;
         rsp_rdata     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         // Strobes and pulses default low; each is raised for exactly one cycle.
         cmd_select    <= 1'b0;
         ack_vec       <= '0;
         timeout_pulse <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  grant_id   <= win_id;
                  last_grant <= win_id;
                  cmd_read   <= req_read[win_id];
                  cmd_addr   <= req_addr[win_id];
                  cmd_wdata  <= req_wdata[win_id];
                  cmd_select <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               wait_count <= '0;
               state      <= ST_WAIT;
            end

            ST_WAIT: begin
               // Ack is checked first so an ack on the final wait cycle wins.
               if (registerAck) begin
                  rsp_error <= registerError;
                  rsp_rdata <= registerReadData;
                  ack_vec   <= 4'b0001 << grant_id;
                  state     <= ST_DONE;
               end else if (wait_count == TIMEOUT_LAST) begin
                  rsp_error     <= 1'b1;
                  rsp_rdata     <= POISON_DATA;
                  ack_vec       <= 4'b0001 << grant_id;
                  timeout_pulse <= 1'b1;
                  state         <= ST_DONE;
               end else begin
                  wait_count <= wait_count + 8'd1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign masterAck0        = ack_vec[0];
   assign masterAck1        = ack_vec[1];
   assign masterAck2        = ack_vec[2];
   assign masterAck3        = ack_vec[3];
   assign masterError       = rsp_error;
   assign masterReadData    = rsp_rdata;

   assign registerSelect    = cmd_select;
   assign registerRead      = cmd_select & cmd_read;
   assign registerAddress   = cmd_addr;
   assign registerWriteData = cmd_wdata;

   assign grantId           = grant_id;
   assign busy              = (state != ST_IDLE);
   assign busTimeout        = timeout_pulse;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
//
// Directed bench for reg_bus_arbiter with TIMEOUT_CYCLES = 4. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  sel;
   logic [3:0]  rd;
   logic [31:0] addr [4];
   logic [31:0] wd   [4];

   logic        m_ack0, m_ack1, m_ack2, m_ack3;
   logic        m_error;
   logic [31:0] m_rdata;
   logic        r_select, r_read;
   logic [31:0] r_addr, r_wdata;
   logic        r_ack, r_err;
   logic [31:0] r_rdata;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout;

   logic [3:0]  mack;
   assign mack = {m_ack3, m_ack2, m_ack1, m_ack0};

   int n_cmp;
   int n_err;
   int sel_count;

   reg_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clockCore        (clk),
      .resetCore        (rst_n),
      .masterSelect0    (sel[0]),
      .masterSelect1    (sel[1]),
      .masterSelect2    (sel[2]),
      .masterSelect3    (sel[3]),
      .masterRead0      (rd[0]),
      .masterRead1      (rd[1]),
      .masterRead2      (rd[2]),
      .masterRead3      (rd[3]),
      .masterAddress0   (addr[0]),
      .masterAddress1   (addr[1]),
      .masterAddress2   (addr[2]),
      .masterAddress3   (addr[3]),
      .masterWriteData0 (wd[0]),
      .masterWriteData1 (wd[1]),
      .masterWriteData2 (wd[2]),
      .masterWriteData3 (wd[3]),
      .masterAck0       (m_ack0),
      .masterAck1       (m_ack1),
      .masterAck2       (m_ack2),
      .masterAck3       (m_ack3),
      .masterError      (m_error),
      .masterReadData   (m_rdata),
      .registerSelect   (r_select),
      .registerRead     (r_read),
      .registerAddress  (r_addr),
      .registerWriteData(r_wdata),
      .registerAck      (r_ack),
      .registerError    (r_err),
      .registerReadData (r_rdata),
      .grantId          (grant),
      .busy             (busy),
      .busTimeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (r_select) sel_count++;
   endtask

   task automatic wait_select();
      for (int k = 0; k < 20 && !r_select; k++) step();
      check("select_wait", 32'(r_select), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      sel_count = 0;
      rst_n     = 1'b1;
      sel       = '0;
      rd        = '0;
      r_ack     = 1'b0;
      r_err     = 1'b0;
      r_rdata   = '0;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 32'h0000_1000 + 32'(i) * 32'h10;
         wd[i]   = 32'h5000_0000 + 32'(i);
      end
      #1;

      // Reset values
      rst_n = 1'b0;
      step();
      step();
      check("rst_busy",    32'(busy),     32'd0);
      check("rst_grant",   32'(grant),    32'd0);
      check("rst_select",  32'(r_select), 32'd0);
      check("rst_read",    32'(r_read),   32'd0);
      check("rst_addr",    r_addr,        32'd0);
      check("rst_wdata",   r_wdata,       32'd0);
      check("rst_mack",    32'(mack),     32'd0);
      check("rst_merr",    32'(m_error),  32'd0);
      check("rst_mrdata",  m_rdata,       32'd0);
      check("rst_timeout", 32'(timeout),  32'd0);
      rst_n = 1'b1;

      // Single read by master2, ack 3 cycles after select; master drops
      // its request right after the grant and still gets its ack.
      addr[2] = 32'h0000_0104;
      rd[2]   = 1'b1;
      sel[2]  = 1'b1;
      step();
      check("rd_select", 32'(r_select), 32'd1);
      check("rd_grant",  32'(grant),    32'd2);
      check("rd_read",   32'(r_read),   32'd1);
      check("rd_addr",   r_addr,        32'h0000_0104);
      check("rd_busy",   32'(busy),     32'd1);
      sel[2] = 1'b0;
      step();
      check("rd_select_low", 32'(r_select), 32'd0);
      check("rd_read_low",   32'(r_read),   32'd0);
      step();
      step();
      check("rd_mack_early", 32'(mack), 32'd0);
      r_ack   = 1'b1;
      r_rdata = 32'h1234_5678;
      step();
      check("rd_mack",    32'(mack),    32'b0100);
      check("rd_mrdata",  m_rdata,      32'h1234_5678);
      check("rd_merr",    32'(m_error), 32'd0);
      check("rd_timeout", 32'(timeout), 32'd0);
      r_ack = 1'b0;
      step();
      check("rd_mack_off", 32'(mack), 32'd0);
      check("rd_idle",     32'(busy), 32'd0);
      check("rd_hold",     m_rdata,   32'h1234_5678);

      // Fairness: all four request continuously for 8 transactions.
      do_reset();
      rd        = 4'b1111;
      sel       = 4'b1111;
      sel_count = 0;
      for (int t = 0; t < 8; t++) begin
         wait_select();
         check("rr_grant", 32'(grant), 32'(t % 4));
         check("rr_addr",  r_addr,     addr[t % 4]);
         r_ack   = 1'b1;
         r_rdata = 32'hA000_0000 + 32'(t);
         step();
         step();
         check("rr_mack",   32'(mack), 32'(4'b0001 << (t % 4)));
         check("rr_mrdata", m_rdata,   32'hA000_0000 + 32'(t));
         r_ack = 1'b0;
         if (t == 7) sel = '0;
      end
      step();
      step();
      check("rr_select_count", 32'(sel_count), 32'd8);
      check("rr_idle",         32'(busy),      32'd0);

      // Timeout on master0 with no ack, then a late ack that is ignored.
      rd[0]  = 1'b1;
      sel[0] = 1'b1;
      step();
      check("to_grant", 32'(grant), 32'd0);
      sel[0] = 1'b0;
      step();
      step();
      step();
      step();
      check("to_mack_early",    32'(mack),    32'd0);
      check("to_timeout_early", 32'(timeout), 32'd0);
      step();
      check("to_mack",    32'(mack),    32'b0001);
      check("to_merr",    32'(m_error), 32'd1);
      check("to_mrdata",  m_rdata,      32'hDEAD_BEEF);
      check("to_timeout", 32'(timeout), 32'd1);
      r_ack   = 1'b1;
      r_rdata = 32'h0BAD_0BAD;
      step();
      check("late_mack",    32'(mack),    32'd0);
      check("late_timeout", 32'(timeout), 32'd0);
      check("late_mrdata",  m_rdata,      32'hDEAD_BEEF);
      step();
      check("late_busy",   32'(busy),     32'd0);
      check("late_select", 32'(r_select), 32'd0);
      check("late_merr",   32'(m_error),  32'd1);
      r_ack = 1'b0;

      // Ack on the final timeout cycle: normal completion.
      rd[1]  = 1'b1;
      sel[1] = 1'b1;
      step();
      check("edge_grant", 32'(grant), 32'd1);
      sel[1] = 1'b0;
      step();
      step();
      step();
      step();
      check("edge_mack_early", 32'(mack), 32'd0);
      r_ack   = 1'b1;
      r_rdata = 32'hC0DE_0001;
      step();
      check("edge_mack",    32'(mack),    32'b0010);
      check("edge_mrdata",  m_rdata,      32'hC0DE_0001);
      check("edge_merr",    32'(m_error), 32'd0);
      check("edge_timeout", 32'(timeout), 32'd0);
      r_ack = 1'b0;
      step();

      // Write by master1 with downstream error.
      rd[1]   = 1'b0;
      addr[1] = 32'h0000_0220;
      wd[1]   = 32'hCAFE_F00D;
      sel[1]  = 1'b1;
      step();
      check("wr_select", 32'(r_select), 32'd1);
      check("wr_grant",  32'(grant),    32'd1);
      check("wr_read",   32'(r_read),   32'd0);
      check("wr_addr",   r_addr,        32'h0000_0220);
      check("wr_wdata",  r_wdata,       32'hCAFE_F00D);
      sel[1] = 1'b0;
      step();
      check("wr_read_wait", 32'(r_read), 32'd0);
      r_ack   = 1'b1;
      r_err   = 1'b1;
      r_rdata = 32'h5555_AAAA;
      step();
      check("wr_mack",   32'(mack),    32'b0010);
      check("wr_merr",   32'(m_error), 32'd1);
      check("wr_mrdata", m_rdata,      32'h5555_AAAA);
      check("wr_read_done", 32'(r_read), 32'd0);
      r_ack = 1'b0;
      r_err = 1'b0;
      step();

      // Reset while master3 is waiting; stray ack afterwards; master0 first.
      rd[3]  = 1'b1;
      sel[3] = 1'b1;
      step();
      check("mr_grant", 32'(grant), 32'd3);
      step();
      check("mr_busy", 32'(busy), 32'd1);
      rst_n  = 1'b0;
      sel[3] = 1'b0;
      step();
      check("mr_busy_rst",  32'(busy),    32'd0);
      check("mr_grant_rst", 32'(grant),   32'd0);
      check("mr_addr_rst",  r_addr,       32'd0);
      check("mr_wdata_rst", r_wdata,      32'd0);
      check("mr_mrdata_rst", m_rdata,     32'd0);
      check("mr_merr_rst",  32'(m_error), 32'd0);
      check("mr_mack_rst",  32'(mack),    32'd0);
      rst_n   = 1'b1;
      r_ack   = 1'b1;
      r_rdata = 32'h7777_7777;
      step();
      check("stray_mack",   32'(mack), 32'd0);
      check("stray_busy",   32'(busy), 32'd0);
      check("stray_mrdata", m_rdata,   32'd0);
      r_ack = 1'b0;
      sel   = 4'b1011;
      step();
      check("mr_first_grant",  32'(grant),    32'd0);
      check("mr_first_select", 32'(r_select), 32'd1);
      sel     = '0;
      r_ack   = 1'b1;
      r_rdata = 32'h0000_0042;
      step();
      step();
      check("mr_first_mack",   32'(mack), 32'b0001);
      check("mr_first_mrdata", m_rdata,   32'h0000_0042);
      r_ack = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
